pwm_ramp_ctrl: RTL

Duty-cycle ramp controller that sits directly upstream of the 8-bit PWM generator and drives its `width` and `cmp` inputs. It accepts a configuration (period width, target compare, step size, hold count) over a valid/ready handshake. It then walks `cmp` from its current value toward the target in saturating steps, changing it only at PWM period boundaries so the generator never sees a mid-period duty change. It provides soft-start/soft-stop for motor and LED loads.

---
 rtl/pwm_pkg.sv | 42 ++++
 rtl/pwm_ramp_ctrl_if.sv | 32 +++
 rtl/pwm_period_tracker.sv | 51 +++++
 rtl/pwm_ramp_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module : pwm_pkg
// Brief  : Shared types and saturating step arithmetic for the PWM ramp slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Next compare value one step toward tgt, clamped so it never passes tgt.
  function automatic logic [PWM_W-1:0] sat_step(
    input logic [PWM_W-1:0] cur,
    input logic [PWM_W-1:0] tgt,
    input logic [PWM_W-1:0] step
  );
    logic [PWM_W:0]   w_inc;
    logic [PWM_W:0]   w_sum;
    logic [PWM_W:0]   w_diff;
    logic [PWM_W-1:0] w_res;
    w_inc  = (step == '0) ? {{PWM_W{1'b0}}, 1'b1} : {1'b0, step};
    w_sum  = {1'b0, cur} + w_inc;
    w_diff = {1'b0, cur} - w_inc;
    if (tgt > cur) begin
      w_res = (w_sum > {1'b0, tgt}) ? tgt : w_sum[PWM_W-1:0];
    end else if (w_diff[PWM_W] || (w_diff[PWM_W-1:0] < tgt)) begin
      w_res = tgt;
    end else begin
      w_res = w_diff[PWM_W-1:0];
    end
    return w_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_ramp_ctrl_if.sv
// ============================================================================
// Module : pwm_ramp_ctrl_if
// Brief  : Configuration valid/ready handshake for the PWM ramp controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_ramp_ctrl_if #(
  parameter int HOLD_W = 8
);
  import pwm_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PWM_W-1:0] cfg_width;
  logic [PWM_W-1:0] cfg_target;
  logic [PWM_W-1:0] cfg_step;
  logic [HOLD_W-1:0] cfg_hold;

  modport master (
    output cfg_valid, cfg_width, cfg_target, cfg_step, cfg_hold,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_width, cfg_target, cfg_step, cfg_hold,
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/pwm_period_tracker.sv
// ============================================================================
// Module : pwm_period_tracker
// Brief  : Tracks downstream PWM periods (width+2 clocks) and paces ramp steps.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_period_tracker
  import pwm_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  wire logic              clk,
  input  wire logic              res,
  input  wire logic [PWM_W-1:0]  width,
  input  wire logic [HOLD_W-1:0] hold,
  input  wire logic              clear,
  input  wire logic              run,
  output logic                   period_end,
  output logic                   step_en
);

  logic [PWM_W:0]    r_pcnt;
  logic [HOLD_W-1:0] r_hcnt;
  logic [PWM_W:0]    w_last;

  // Nine-bit terminal count keeps width=255 (period 257) representable.
  assign w_last     = {1'b0, width} + {{PWM_W{1'b0}}, 1'b1};
  assign period_end = (r_pcnt == w_last);
  assign step_en    = run && period_end && (r_hcnt == hold);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pcnt <= '0;
      r_hcnt <= '0;
    end else if (clear) begin
      r_pcnt <= '0;
      r_hcnt <= '0;
    end else begin
      r_pcnt <= period_end ? '0 : r_pcnt + 1'b1;
      if (step_en) begin
        r_hcnt <= '0;
      end else if (run && period_end) begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
// ============================================================================
// Module : pwm_ramp_ctrl
// Brief  : Walks the PWM compare value toward a target in saturating steps at
//          period boundaries. Define PWM_RAMP_RETARGET_EN to accept mid-ramp.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  wire logic        clk,
  input  wire logic        res,
  pwm_ramp_ctrl_if.slave   cfg,
  output logic [PWM_W-1:0] width,
  output logic [PWM_W-1:0] cmp,
  output logic             busy,
  output logic             done
);

  ramp_state_t       r_state;
  ramp_state_t       w_state_nxt;
  logic [PWM_W-1:0]  r_target;
  logic [PWM_W-1:0]  r_step;
  logic [HOLD_W-1:0] r_hold;
  logic [PWM_W-1:0]  w_cmp_nxt;
  logic              w_accept;
  logic              w_noop;
  logic              w_period_end;
  logic              w_step_en;
  logic              w_step;
  logic              w_last_step;

  assign w_accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign w_noop      = (cfg.cfg_target == cmp);
  assign w_cmp_nxt   = sat_step(cmp, r_target, r_step);
  // A new configuration wins over a step landing on the same edge.
  assign w_step      = (r_state == RAMP) && w_period_end && w_step_en && !w_accept;
  assign w_last_step = w_step && (w_cmp_nxt == r_target);

  pwm_period_tracker #(
    .HOLD_W (HOLD_W)
  ) u_tracker (
    .clk        (clk),
    .res        (res),
    .width      (width),
    .hold       (r_hold),
    .clear      (w_accept),
    .run        (r_state == RAMP),
    .period_end (w_period_end),
    .step_en    (w_step_en)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_noop ? IDLE : RAMP;
    end else if (w_last_step) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    busy = (r_state == RAMP);
`ifdef PWM_RAMP_RETARGET_EN
    cfg.cfg_ready = 1'b1;
`else
    cfg.cfg_ready = (r_state == IDLE);
`endif
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      width    <= '0;
      cmp      <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_hold   <= '0;
      done     <= 1'b0;
    end else begin
      done <= w_accept ? w_noop : w_last_step;
      if (w_accept) begin
        width    <= cfg.cfg_width;
        r_target <= cfg.cfg_target;
        r_step   <= cfg.cfg_step;
        r_hold   <= cfg.cfg_hold;
      end else if (w_step) begin
        cmp <= w_cmp_nxt;
      end
    end
  end

endmodule

`default_nettype wire
